// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, long-latency result handshake, RF write port.
// Latency: none (wiring only).
// Backpressure: lsu_valid_i/lsu_ready_o handshake; the ALU side has none, stall_o throttles it upstream.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  // ALU result (single cycle, never backpressured)
  logic                     alu_valid_i;
  logic [4:0]               alu_rd_i;
  logic [XLEN-1:0]          alu_data_i;
  // Long-latency result handshake
  logic                     lsu_valid_i;
  logic [4:0]               lsu_rd_i;
  logic [XLEN-1:0]          lsu_data_i;
  logic                     lsu_ready_o;
  // Register-file write port and status
  logic                     rf_we_o;
  logic [4:0]               rf_rd_o;
  logic [XLEN-1:0]          rf_wdata_o;
  logic                     stall_o;
  logic [$clog2(DEPTH):0]   fifo_count_o;

  // Arbiter side
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o,
    output rf_we_o, rf_rd_o, rf_wdata_o, stall_o, fifo_count_o
  );

  // Producer / register-file side
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o,
    input  rf_we_o, rf_rd_o, rf_wdata_o, stall_o, fifo_count_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority, long-latency results are buffered in order.
// Latency: one cycle from accept / FIFO pop decision to rf_we_o.
// Backpressure: lsu_ready_o = registered count < DEPTH; stall_o when the FIFO head waits STARVE_LIMIT cycles.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LIMIT_C = AW'(STARVE_LIMIT);

  // FIFO storage and bookkeeping; count is kept apart from the pointers so
  // that full and empty are never ambiguous after wrap-around
  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  // Starvation age of the FIFO head
  logic [AW-1:0]   age;
  logic [AW-1:0]   age_nxt;

  // Registered write port
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            we_nxt;
  logic [4:0]      rd_nxt;
  logic [XLEN-1:0] wdata_nxt;

  // Per-cycle decode
  logic            alu_req;
  logic            lsu_ready;
  logic            lsu_fire;
  logic            lsu_keep;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Readiness depends only on the registered count, so a full FIFO refuses
  // a new entry even in a cycle where it also pops.
  assign lsu_ready  = (count < DEPTH_C);
  assign fifo_empty = (count == '0);
  assign alu_req    = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
  assign lsu_fire   = bus.lsu_valid_i && lsu_ready;
  // An x0 result is consumed and dropped: it never occupies a slot.
  assign lsu_keep   = lsu_fire && (bus.lsu_rd_i != 5'd0);

  // Priority select: ALU, then FIFO head, then bypass of a fresh LSU result
  always_comb begin
    we_nxt    = 1'b0;
    rd_nxt    = rf_rd;
    wdata_nxt = rf_wdata;
    push      = 1'b0;
    pop       = 1'b0;
    if (alu_req) begin
      we_nxt    = 1'b1;
      rd_nxt    = bus.alu_rd_i;
      wdata_nxt = bus.alu_data_i;
      push      = lsu_keep;
    end else if (!fifo_empty) begin
      we_nxt    = 1'b1;
      rd_nxt    = fifo_rd[rd_ptr];
      wdata_nxt = fifo_data[rd_ptr];
      pop       = 1'b1;
      push      = lsu_keep;
    end else if (lsu_keep) begin
      // Bypass is only legal with an empty FIFO, which keeps results in order.
      we_nxt    = 1'b1;
      rd_nxt    = bus.lsu_rd_i;
      wdata_nxt = bus.lsu_data_i;
    end
  end

  // Next occupancy and head age
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
    age_nxt   = age;
    if (pop || fifo_empty) begin
      age_nxt = '0;
    end else if (age != LIMIT_C) begin
      age_nxt = age + 1'b1;
    end
  end

  // FIFO entry storage; contents are don't-care until pushed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd_i;
      fifo_data[wr_ptr] <= bus.lsu_data_i;
    end
  end

  // FIFO pointers, count and head age
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      age   <= age_nxt;
    end
  end

  // Register-file write port; address and data hold when nothing is written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= we_nxt;
      rf_rd    <= rd_nxt;
      rf_wdata <= wdata_nxt;
    end
  end

  assign bus.lsu_ready_o  = lsu_ready;
  assign bus.rf_we_o      = rf_we;
  assign bus.rf_rd_o      = rf_rd;
  assign bus.rf_wdata_o   = rf_wdata;
  assign bus.stall_o      = (age == LIMIT_C);
  assign bus.fifo_count_o = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic.
// Reference model: result queue with a head-age integer, evaluated per cycle.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 1 + 5 + XLEN + CW + 1;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  ent_t            q[$];
  int              m_age;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wdata;
  logic            m_rdy_exp;
  logic            m_rdy_obs;
  logic            m_fire;

  function automatic logic [VW-1:0] expv();
    return {m_we, m_rd, m_wdata, CW'(q.size()), (m_age == LIMIT)};
  endfunction

  function automatic logic [VW-1:0] obsv();
    return {bus.rf_we_o, bus.rf_rd_o, bus.rf_wdata_o, bus.fifo_count_o, bus.stall_o};
  endfunction

  task automatic model_reset();
    q.delete();
    m_age   = 0;
    m_we    = 1'b0;
    m_rd    = '0;
    m_wdata = '0;
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [XLEN-1:0] ld);
    bus.alu_valid_i = av;
    bus.alu_rd_i    = ar;
    bus.alu_data_i  = ad;
    bus.lsu_valid_i = lv;
    bus.lsu_rd_i    = lr;
    bus.lsu_data_i  = ld;
  endtask

  // Advance one clock; the model applies the arbitration rules to the inputs
  // currently driven and the outputs are left settled 1 time unit after the edge.
  task automatic step();
    ent_t e;
    bit   alu_req, keep, was_empty, popped;
    m_rdy_obs = bus.lsu_ready_o;
    m_rdy_exp = (q.size() < DEPTH);
    m_fire    = bus.lsu_valid_i && m_rdy_exp;
    keep      = m_fire && (bus.lsu_rd_i != 5'd0);
    alu_req   = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    was_empty = (q.size() == 0);
    popped    = 1'b0;
    m_we      = 1'b0;
    e.rd      = bus.lsu_rd_i;
    e.data    = bus.lsu_data_i;
    if (alu_req) begin
      m_we = 1'b1; m_rd = bus.alu_rd_i; m_wdata = bus.alu_data_i;
      if (keep) q.push_back(e);
    end else if (!was_empty) begin
      ent_t h;
      h = q.pop_front();
      popped = 1'b1;
      m_we = 1'b1; m_rd = h.rd; m_wdata = h.data;
      if (keep) q.push_back(e);
    end else if (keep) begin
      m_we = 1'b1; m_rd = e.rd; m_wdata = e.data;
    end
    if (popped || was_empty) m_age = 0;
    else if (m_age < LIMIT) m_age = m_age + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if (obsv() !== expv()) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obsv(), expv()); end
    n_cmp++;
    if (bus.lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.lsu_ready_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.rf_we_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_we: got %b want 0", bus.rf_we_o); end
    end
  endtask

  task automatic test_reset_midrun();
    drive(1, 1, 32'h1, 1, 11, 32'hB11);
    step();
    drive(1, 2, 32'h2, 1, 12, 32'hB12);
    step();
    n_cmp++;
    if (bus.fifo_count_o !== CW'(2)) begin n_err++; $display("FAIL midrun_fill: got %0d want 2", bus.fifo_count_o); end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.rf_we_o, bus.fifo_count_o, bus.stall_o} !== {1'b0, CW'(0), 1'b0}) begin
      n_err++; $display("FAIL midrun_async_reset: got we=%b cnt=%0d stall=%b want 0/0/0",
                        bus.rf_we_o, bus.fifo_count_o, bus.stall_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obsv() !== expv() || bus.rf_we_o !== 1'b0) begin
        n_err++; $display("FAIL midrun_after_release: got %h want %h", obsv(), expv());
      end
    end
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
    step();
    n_cmp++;
    if (obsv() !== {1'b1, 5'd5, 32'hDEADBEEF, CW'(0), 1'b0}) begin
      n_err++; $display("FAIL bypass: got %h want we=1 rd=5 data=deadbeef cnt=0", obsv());
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    n_cmp++;
    if (obsv() !== expv()) begin n_err++; $display("FAIL bypass_idle: got %h want %h", obsv(), expv()); end
  endtask

  task automatic test_conflict();
    logic [VW-1:0] want [3];
    want[0] = {1'b1, 5'd3, 32'h11, CW'(1), 1'b0};
    want[1] = {1'b1, 5'd4, 32'h33, CW'(1), 1'b0};
    want[2] = {1'b1, 5'd7, 32'h22, CW'(0), 1'b0};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1, 3, 32'h11, 1, 7, 32'h22);
        1:       drive(1, 4, 32'h33, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
      step();
      n_cmp++;
      if (obsv() !== want[i]) begin
        n_err++; $display("FAIL conflict_order[%0d]: got %h want %h", i, obsv(), want[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [4:0] offers [3];
    logic [4:0] seen[$];
    int idx = 0;
    offers[0] = 5'd8; offers[1] = 5'd9; offers[2] = 5'd10;
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(20 + i), 32'hA0 + i, idx < 3, offers[idx % 3], 32'h80 + offers[idx % 3]);
      step();
      n_cmp++;
      if (m_rdy_obs !== m_rdy_exp) begin n_err++; $display("FAIL full_ready[%0d]: got %b want %b", i, m_rdy_obs, m_rdy_exp); end
      if (idx == 2) begin
        n_cmp++;
        if (m_rdy_obs !== 1'b0) begin n_err++; $display("FAIL full_third_offer_ready: got %b want 0", m_rdy_obs); end
      end
      n_cmp++;
      if (obsv() !== expv()) begin n_err++; $display("FAIL full_alu_phase[%0d]: got %h want %h", i, obsv(), expv()); end
      if (m_fire) idx++;
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, idx < 3, offers[idx % 3], 32'h80 + offers[idx % 3]);
      step();
      if (m_fire) idx++;
      if (bus.rf_we_o && bus.rf_rd_o >= 5'd8 && bus.rf_rd_o <= 5'd10) seen.push_back(bus.rf_rd_o);
      n_cmp++;
      if (obsv() !== expv()) begin n_err++; $display("FAIL full_drain[%0d]: got %h want %h", i, obsv(), expv()); end
    end
    n_cmp++;
    if (seen.size() != 3 || seen[0] !== 5'd8 || seen[1] !== 5'd9 || seen[2] !== 5'd10) begin
      n_err++; $display("FAIL full_retire_order: got %p want 8 9 10", seen);
    end
  endtask

  task automatic test_starvation();
    int waited = 0;
    drive(1, 1, 32'h1, 1, 13, 32'hC0DE);
    step();
    while (bus.stall_o !== 1'b1 && waited < 12) begin
      drive(1, 5'(2 + waited), 32'h2, 0, 0, 0);
      step();
      waited++;
      n_cmp++;
      if (obsv() !== expv()) begin n_err++; $display("FAIL starve_wait[%0d]: got %h want %h", waited, obsv(), expv()); end
    end
    n_cmp++;
    if (waited != LIMIT) begin n_err++; $display("FAIL starve_rise: got %0d cycles want %0d", waited, LIMIT); end
    drive(1, 5'd30, 32'h30, 0, 0, 0);
    step();
    n_cmp++;
    if ({bus.rf_we_o, bus.rf_rd_o, bus.stall_o} !== {1'b1, 5'd30, 1'b1}) begin
      n_err++; $display("FAIL starve_alu_wins: got we=%b rd=%0d stall=%b want 1/30/1", bus.rf_we_o, bus.rf_rd_o, bus.stall_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    n_cmp++;
    if ({bus.rf_we_o, bus.rf_rd_o, bus.rf_wdata_o, bus.stall_o} !== {1'b1, 5'd13, 32'hC0DE, 1'b0}) begin
      n_err++; $display("FAIL starve_release: got we=%b rd=%0d data=%h stall=%b want 1/13/c0de/0",
                        bus.rf_we_o, bus.rf_rd_o, bus.rf_wdata_o, bus.stall_o);
    end
  endtask

  task automatic test_x0();
    drive(1, 0, 32'hFF, 1, 0, 32'hEE);
    step();
    n_cmp++;
    if ({bus.rf_we_o, bus.fifo_count_o, bus.lsu_ready_o} !== {1'b0, CW'(0), 1'b1}) begin
      n_err++; $display("FAIL x0_both: got we=%b cnt=%0d rdy=%b want 0/0/1", bus.rf_we_o, bus.fifo_count_o, bus.lsu_ready_o);
    end
    drive(1, 1, 32'h1, 1, 6, 32'h66);
    step();
    drive(1, 0, 32'hFF, 0, 0, 0);
    step();
    n_cmp++;
    if ({bus.rf_we_o, bus.rf_rd_o, bus.rf_wdata_o} !== {1'b1, 5'd6, 32'h66}) begin
      n_err++; $display("FAIL x0_alu_fifo: got we=%b rd=%0d data=%h want 1/6/66", bus.rf_we_o, bus.rf_rd_o, bus.rf_wdata_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ar, lr;
      ar = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      lr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom_range(0, 99) < 55), ar, $urandom, ($urandom_range(0, 99) < 50), lr, $urandom);
      step();
      n_cmp++;
      if (m_rdy_obs !== m_rdy_exp) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, m_rdy_obs, m_rdy_exp); end
      n_cmp++;
      if (obsv() !== expv()) begin n_err++; $display("FAIL rand_out[%0d]: got %h want %h", i, obsv(), expv()); end
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obsv() !== expv()) begin n_err++; $display("FAIL rand_drain[%0d]: got %h want %h", i, obsv(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_full();
    test_starvation();
    test_x0();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
